line_sensor_sampler: RTL and testbench

Front-end for the balance-car line/position sensor array. Synchronises the eight raw sensor inputs, samples them on a programmable tick, debounces each pattern over several ticks, and rejects codes that are not a legal single-bit or adjacent-pair pattern. Accepted patterns drive the `process` bus consumed by the downstream position linearizer, with a per-sample `valid` strobe and fault/glitch diagnostics.

---
 rtl/line_sensor_sampler.sv | 184 ++++++++++++++++++
 tb/tb_line_sensor_sampler.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_sampler.sv
// line_sensor_sampler
// Front-end for the balance-car line/position sensor array. The raw sensor
// levels are synchronised, sampled once per divider tick, debounced over
// DEBOUNCE consecutive ticks and screened against the 16 legal codes
// (0x00, one-hot, adjacent pair). Accepted codes appear on `process` with a
// one-cycle `valid` strobe. `fault` flags a run of STALE_LIMIT ticks without
// an accepted code. `glitch_cnt` counts stable but illegal patterns.
module line_sensor_sampler #(
    parameter int DIV         = 500,  // clock cycles per sample tick, >= 2
    parameter int DEBOUNCE    = 4,    // identical ticks needed for stability, 1..15
    parameter int STALE_LIMIT = 255   // ticks without acceptance before fault, 1..255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] sensor_raw,
    input  logic       enable,
    output logic [7:0] process,
    output logic       valid,
    output logic       fault,
    output logic [7:0] glitch_cnt
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int              CNT_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]      STAB_FULL  = 4'(DEBOUNCE);
    localparam logic [7:0]      STALE_FULL = 8'(STALE_LIMIT);
    localparam logic [7:0]      GLITCH_MAX = 8'hFF;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [7:0]       sync1_reg;
    logic [7:0]       sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [7:0]       cand_reg;
    logic [7:0]       cand_next;
    logic [3:0]       stab_reg;
    logic [3:0]       stab_next;
    logic [7:0]       stale_reg;
    logic [7:0]       stale_next;
    logic [7:0]       process_reg;
    logic [7:0]       process_next;
    logic             valid_reg;
    logic             valid_next;
    logic             fault_reg;
    logic             fault_next;
    logic [7:0]       glitch_reg;
    logic [7:0]       glitch_next;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       tick;          // sampling instant, one cycle per DIV while enabled
    logic       s_match;       // synchronised input equals the held candidate
    logic       stable;        // tick on which the candidate has DEBOUNCE matches
    logic       first_stable;  // stable, and this is the first such tick for the candidate
    logic       legal;         // candidate is one of the 16 accepted codes
    logic       accept;        // stable and legal: publish the code
    logic       reject_new;    // stable and illegal for the first time: count a glitch
    logic [7:0] onehot_hit;
    logic [6:0] pair_hit;

    assign tick    = enable && (cnt_reg == CNT_LAST);
    assign s_match = (sync2_reg == cand_reg);

    // Legal-code screen on the candidate as it stands after this tick's update,
    // so DEBOUNCE=1 judges the freshly sampled value.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_onehot
            assign onehot_hit[gi] = (cand_next == (8'd1 << gi));
        end
        for (genvar gi = 0; gi < 7; gi++) begin : g_pair
            assign pair_hit[gi] = (cand_next == (8'd3 << gi));
        end
    endgenerate

    assign legal = (cand_next == 8'h00) || (|onehot_hit) || (|pair_hit);

    assign stable       = tick && (stab_next == STAB_FULL);
    // A candidate that was already saturated and still matches has been
    // reported before; anything else reaching DEBOUNCE is a fresh arrival.
    assign first_stable = stable && !(s_match && (stab_reg == STAB_FULL));
    assign accept       = stable && legal;
    assign reject_new   = first_stable && !legal;

    // ------------------------------------------------------------------
    // Two-flop synchroniser, free running regardless of enable
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg <= 8'h00;
            sync2_reg <= 8'h00;
        end else begin
            sync1_reg <= sensor_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Divider next state: counts 0..DIV-1 while enabled, parked at 0 otherwise
    always_comb begin
        cnt_next = cnt_reg;
        if (!enable) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_next = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // Debounce next state: track the candidate and how many ticks it has held
    always_comb begin
        cand_next = cand_reg;
        stab_next = stab_reg;
        if (!enable) begin
            // Dropping enable discards partial stability; a full run is needed again.
            stab_next = 4'd0;
        end else if (tick) begin
            if (s_match) begin
                stab_next = (stab_reg == STAB_FULL) ? stab_reg : stab_reg + 4'd1;
            end else begin
                cand_next = sync2_reg;
                stab_next = 4'd1;
            end
        end
    end

    // Output/diagnostic next state: acceptance, staleness and glitch counting
    always_comb begin
        process_next = process_reg;
        valid_next   = 1'b0;
        stale_next   = stale_reg;
        fault_next   = fault_reg;
        glitch_next  = glitch_reg;
        if (tick) begin
            if (accept) begin
                // Acceptance wins over a stale counter that would saturate now.
                process_next = cand_next;
                valid_next   = 1'b1;
                stale_next   = 8'h00;
                fault_next   = 1'b0;
            end else begin
                stale_next = (stale_reg == STALE_FULL) ? stale_reg : stale_reg + 8'd1;
                fault_next = (stale_next == STALE_FULL);
            end
            if (reject_new && (glitch_reg != GLITCH_MAX)) begin
                glitch_next = glitch_reg + 8'd1;
            end
        end
    end

    // Register all state; asynchronous reset clears everything
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg     <= '0;
            cand_reg    <= 8'h00;
            stab_reg    <= 4'd0;
            stale_reg   <= 8'h00;
            process_reg <= 8'h00;
            valid_reg   <= 1'b0;
            fault_reg   <= 1'b0;
            glitch_reg  <= 8'h00;
        end else begin
            cnt_reg     <= cnt_next;
            cand_reg    <= cand_next;
            stab_reg    <= stab_next;
            stale_reg   <= stale_next;
            process_reg <= process_next;
            valid_reg   <= valid_next;
            fault_reg   <= fault_next;
            glitch_reg  <= glitch_next;
        end
    end

    assign process    = process_reg;
    assign valid      = valid_reg;
    assign fault      = fault_reg;
    assign glitch_cnt = glitch_reg;

endmodule

// File: tb/tb_line_sensor_sampler.sv
// tb_line_sensor_sampler
// Directed bench for line_sensor_sampler with DIV=4, DEBOUNCE=3, STALE_LIMIT=5.
// Inputs are driven and outputs sampled on the falling clock edge. Edge
// numbering below counts rising edges since the last reset release or
// enable rise; divider ticks update state on every 4th such edge.
module tb_line_sensor_sampler;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] sensor_raw;
    logic       enable;
    logic [7:0] process_w;
    logic       valid_w;
    logic       fault_w;
    logic [7:0] glitch_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    line_sensor_sampler #(
        .DIV        (4),
        .DEBOUNCE   (3),
        .STALE_LIMIT(5)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sensor_raw (sensor_raw),
        .enable     (enable),
        .process    (process_w),
        .valid      (valid_w),
        .fault      (fault_w),
        .glitch_cnt (glitch_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for valid; flag any change of process away from hold_val meanwhile.
    task automatic wait_valid(input int limit, input logic [7:0] hold_val,
                              output int cycles, output bit seen, output bit bad);
        cycles = 0;
        seen   = 1'b0;
        bad    = 1'b0;
        while (!seen && cycles < limit) begin
            step(1);
            cycles++;
            if (valid_w === 1'b1) seen = 1'b1;
            else if (process_w !== hold_val) bad = 1'b1;
        end
    endtask

    initial begin
        int  cycles;
        bit  seen;
        bit  bad;
        bit  any_valid;
        bit  any_fault;

        // ---------------- reset / initial ----------------
        reset_n    = 1'b0;
        enable     = 1'b1;
        sensor_raw = 8'h00;
        step(3);
        check("reset_process", {24'd0, process_w}, 32'h00);
        check("reset_valid",   {31'd0, valid_w},   32'h0);
        check("reset_fault",   {31'd0, fault_w},   32'h0);
        check("reset_glitch",  {24'd0, glitch_w},  32'h00);
        reset_n = 1'b1;
        // Ticks at edges 4, 8, 12, ...; 0x00 matches the reset candidate, so the
        // third tick (edge 12) accepts, then every tick after.
        any_fault = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("init_valid", {31'd0, valid_w}, {31'd0, (k >= 12) && (k % 4 == 0)});
            if (fault_w !== 1'b0 || glitch_w !== 8'h00) any_fault = 1'b1;
        end
        check("init_process", {24'd0, process_w}, 32'h00);
        check("init_fault_glitch_quiet", {31'd0, any_fault}, 32'h0);
        $display("step init: valid every 4 cycles from cycle 12, process=0x%0h", process_w);

        // ---------------- legal step 0x00 -> 0x18 ----------------
        // Change just after a tick: seen at edge 2, ticks at 4/8/12 -> valid at 12.
        sensor_raw = 8'h18;
        wait_valid(14, 8'h00, cycles, seen, bad);
        check("step_seen",    {31'd0, seen}, 32'h1);
        check("step_latency", cycles,        32'd12);
        check("step_process", {24'd0, process_w}, 32'h18);
        check("step_no_intermediate", {31'd0, bad}, 32'h0);
        $display("step legal: 0x18 accepted after %0d cycles", cycles);

        // ---------------- bounce rejection ----------------
        // Toggle 0x08/0x10 each tick; 5 unaccepted ticks later fault rises.
        any_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sensor_raw = (i % 2 == 0) ? 8'h08 : 8'h10;
            for (int j = 0; j < 4; j++) begin
                step(1);
                if (valid_w === 1'b1) any_valid = 1'b1;
            end
            check("bounce_fault", {31'd0, fault_w}, {31'd0, (i == 4)});
        end
        check("bounce_no_valid", {31'd0, any_valid}, 32'h0);
        check("bounce_process",  {24'd0, process_w}, 32'h18);
        $display("step bounce: fault=%0d process=0x%0h", fault_w, process_w);

        // ---------------- illegal pattern 0x81 ----------------
        sensor_raw = 8'h81;
        any_valid  = 1'b0;
        for (int j = 0; j < 40; j++) begin
            step(1);
            if (valid_w === 1'b1) any_valid = 1'b1;
        end
        check("illegal_glitch",   {24'd0, glitch_w},  32'd1);
        check("illegal_process",  {24'd0, process_w}, 32'h18);
        check("illegal_no_valid", {31'd0, any_valid}, 32'h0);
        check("illegal_fault",    {31'd0, fault_w},   32'h1);
        $display("step illegal: glitch_cnt=%0d", glitch_w);

        // Restore a legal code (change lands right after a tick edge).
        sensor_raw = 8'h01;
        wait_valid(14, 8'h18, cycles, seen, bad);
        check("recover_seen",    {31'd0, seen},      32'h1);
        check("recover_latency", cycles,             32'd12);
        check("recover_process", {24'd0, process_w}, 32'h01);
        check("recover_fault",   {31'd0, fault_w},   32'h0);
        $display("step recover: process=0x%0h fault=%0d", process_w, fault_w);

        // ---------------- glitch saturation ----------------
        // Each illegal pattern held 12 cycles becomes stable exactly once.
        for (int i = 0; i < 300; i++) begin
            sensor_raw = (i % 2 == 0) ? 8'h81 : 8'h05;
            step(12);
            if (i == 0)   check("glitch_first", {24'd0, glitch_w}, 32'd2);
            if (i == 252) check("glitch_254",   {24'd0, glitch_w}, 32'd254);
            if (i == 253) check("glitch_255",   {24'd0, glitch_w}, 32'd255);
        end
        check("glitch_saturated", {24'd0, glitch_w},  32'd255);
        check("glitch_process",   {24'd0, process_w}, 32'h01);
        check("glitch_fault",     {31'd0, fault_w},   32'h1);
        $display("step glitch: glitch_cnt=%0d after 300 illegal patterns", glitch_w);

        // ---------------- enable drop mid-debounce ----------------
        sensor_raw = 8'h02;
        step(8);                // two matching ticks taken
        enable    = 1'b0;
        any_valid = 1'b0;
        for (int j = 0; j < 6; j++) begin
            step(1);
            if (valid_w === 1'b1) any_valid = 1'b1;
        end
        check("disable_no_valid", {31'd0, any_valid}, 32'h0);
        check("disable_process",  {24'd0, process_w}, 32'h01);
        enable = 1'b1;
        // First tick 4 cycles after enable; three fresh ticks needed -> 12.
        wait_valid(14, 8'h01, cycles, seen, bad);
        check("reenable_seen",    {31'd0, seen},      32'h1);
        check("reenable_latency", cycles,             32'd12);
        check("reenable_process", {24'd0, process_w}, 32'h02);
        check("reenable_fault",   {31'd0, fault_w},   32'h0);
        $display("step enable: 0x02 accepted %0d cycles after re-enable", cycles);

        // ---------------- asynchronous reset mid-sequence ----------------
        sensor_raw = 8'h04;
        step(6);
        reset_n = 1'b0;
        #1;
        check("areset_process", {24'd0, process_w}, 32'h00);
        check("areset_valid",   {31'd0, valid_w},   32'h0);
        check("areset_fault",   {31'd0, fault_w},   32'h0);
        check("areset_glitch",  {24'd0, glitch_w},  32'h00);
        step(1);
        reset_n = 1'b1;
        wait_valid(14, 8'h00, cycles, seen, bad);
        check("post_reset_seen",    {31'd0, seen},      32'h1);
        check("post_reset_latency", cycles,             32'd12);
        check("post_reset_process", {24'd0, process_w}, 32'h04);
        $display("step reset: outputs cleared, 0x04 accepted %0d cycles after release", cycles);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
